// File: rtl/joy_db9_scan_ctrl.sv
// DB9 joystick chain scanner: periodically loads and shifts the 16-bit chain and
// publishes both ports, handing the chain to an external requester between scans.
module joy_db9_scan_ctrl #(
    parameter int CLK_DIV     = 16,
    parameter int IDLE_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_req,
    input  logic       ext_clk,
    input  logic       ext_load,
    output logic       ext_grant,
    output logic       joy_clk,
    output logic       joy_load,
    input  logic       joy_data,
    output logic       joy_xdata,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       joy_valid
);

    localparam int MAXC = (IDLE_CYCLES > CLK_DIV) ? IDLE_CYCLES : CLK_DIV;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_EXT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    half_q, half_d;
    logic [15:0]   shift_q, shift_d;
    logic [7:0]    joy1_q, joy1_d;
    logic [7:0]    joy2_q, joy2_d;
    logic          valid_q, valid_d;
    logic          clk_q, clk_d;
    logic          load_q, load_d;
    logic          grant_q, grant_d;

    // The external requester drives the chain lines directly while it holds the grant.
    assign joy_xdata = joy_data;
    assign joy_clk   = grant_q ? ext_clk : clk_q;
    assign joy_load  = grant_q ? ext_load : load_q;
    assign ext_grant = grant_q;
    assign joy1      = joy1_q;
    assign joy2      = joy2_q;
    assign joy_valid = valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        shift_d = shift_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        valid_d = 1'b0;
        clk_d   = clk_q;
        load_d  = load_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (ext_req) begin
                    state_d = S_EXT;
                    grant_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(IDLE_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    load_d  = 1'b0;
                    clk_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                    load_d  = 1'b1;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // half_q counts half periods: even = low phase of bit half_q/2, odd = high phase.
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!half_q[0]) begin
                        shift_d[half_q[4:1]] = joy_data;
                    end
                    if (half_q == 5'd31) begin
                        state_d = S_DONE;
                        clk_d   = 1'b1;
                        joy1_d  = ~shift_q[7:0];
                        joy2_d  = ~shift_q[15:8];
                        valid_d = 1'b1;
                    end else begin
                        half_d = half_q + 1'b1;
                        clk_d  = ~half_q[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                clk_d  = 1'b1;
                load_d = 1'b1;
                cnt_d  = '0;
                if (ext_req) begin
                    state_d = S_EXT;
                    grant_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXT: begin
                if (!ext_req) begin
                    state_d = S_IDLE;
                    grant_d = 1'b0;
                    clk_d   = 1'b1;
                    load_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b1;
                load_d  = 1'b1;
                grant_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            shift_q <= '0;
            joy1_q  <= '0;
            joy2_q  <= '0;
            valid_q <= 1'b0;
            clk_q   <= 1'b1;
            load_q  <= 1'b1;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            shift_q <= shift_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            valid_q <= valid_d;
            clk_q   <= clk_d;
            load_q  <= load_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_joy_db9_scan_ctrl.sv
// Self-checking bench for joy_db9_scan_ctrl: behavioural DB9 chain model, scan-period
// arithmetic, external handover and mid-scan reset.
module tb_joy_db9_scan_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int IDLE_CYCLES = 4;
    localparam int PERIOD      = IDLE_CYCLES + 33 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_req;
    logic       ext_clk;
    logic       ext_load;
    logic       ext_grant;
    logic       joy_clk;
    logic       joy_load;
    logic       joy_data = 1'b0;
    logic       joy_xdata;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       joy_valid;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;

    logic [15:0] pattern  = 16'h0000;
    logic [15:0] chain_sr = 16'h0000;
    logic        prev_clk = 1'b1;
    logic        chain_en = 1'b0;
    logic [7:0]  exp_j1   = 8'h00;
    logic [7:0]  exp_j2   = 8'h00;

    joy_db9_scan_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .IDLE_CYCLES(IDLE_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ext_req  (ext_req),
        .ext_clk  (ext_clk),
        .ext_load (ext_load),
        .ext_grant(ext_grant),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .joy_data (joy_data),
        .joy_xdata(joy_xdata),
        .joy1     (joy1),
        .joy2     (joy2),
        .joy_valid(joy_valid)
    );

    always #5 clk = ~clk;

    // Chain model: parallel load while joy_load is low, shift one bit per joy_clk rising edge.
    always @(negedge clk) begin
        if (chain_en) begin
            if (!joy_load) chain_sr = pattern;
            else if (joy_clk && !prev_clk) chain_sr = {1'b1, chain_sr[15:1]};
            joy_data = chain_sr[0];
        end else begin
            joy_data = 1'($urandom_range(0, 1));
        end
        prev_clk = joy_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("xdata", 32'(joy_xdata), 32'(joy_data));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_clk"}, 32'(joy_clk), 32'd1);
        chk({tag, "_load"}, 32'(joy_load), 32'd1);
        chk({tag, "_grant"}, 32'(ext_grant), 32'd0);
        chk({tag, "_joy1"}, 32'(joy1), 32'd0);
        chk({tag, "_joy2"}, 32'(joy2), 32'd0);
        chk({tag, "_valid"}, 32'(joy_valid), 32'd0);
    endtask

    // Starts at the first IDLE cycle (counted as 1) and returns at the joy_valid cycle.
    task automatic scan(input logic [15:0] pat, input int req_at, input int rst_at,
                        input string tag);
        int   n;
        int   loads;
        int   rises;
        logic prv;
        pattern = pat;
        chain_en = 1'b1;
        loads = 0;
        rises = 0;
        prv = 1'b1;
        for (n = 1; n <= 200; n++) begin
            if (joy_valid) break;
            if (!joy_load) loads++;
            if (joy_clk && !prv) rises++;
            prv = joy_clk;
            if (n == req_at) ext_req = 1'b1;
            if (n == rst_at) begin
                reset = 1'b1;
                step();
                exp_j1 = 8'h00;
                exp_j2 = 8'h00;
                chk_reset_outputs({tag, "_abort"});
                reset = 1'b0;
                return;
            end
            step();
        end
        exp_j1 = ~pat[7:0];
        exp_j2 = ~pat[15:8];
        chk({tag, "_period"}, 32'(n), 32'(PERIOD));
        chk({tag, "_loadlow"}, 32'(loads), 32'(CLK_DIV));
        chk({tag, "_rises"}, 32'(rises), 32'd16);
        chk({tag, "_joy1"}, 32'(joy1), 32'(exp_j1));
        chk({tag, "_joy2"}, 32'(joy2), 32'(exp_j2));
    endtask

    task automatic after_done(input logic exp_grant, input string tag);
        step();
        chk({tag, "_strobe"}, 32'(joy_valid), 32'd0);
        chk({tag, "_grant"}, 32'(ext_grant), 32'(exp_grant));
    endtask

    // Entered on an EXT cycle; leaves on the first IDLE cycle after ext_req drops.
    task automatic ext_phase(input int cycles, input string tag);
        chain_en = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            ext_clk  = 1'($urandom_range(0, 1));
            ext_load = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_pclk"}, 32'(joy_clk), 32'(ext_clk));
            chk({tag, "_pload"}, 32'(joy_load), 32'(ext_load));
            chk({tag, "_grant"}, 32'(ext_grant), 32'd1);
            chk({tag, "_valid"}, 32'(joy_valid), 32'd0);
            chk({tag, "_hold1"}, 32'(joy1), 32'(exp_j1));
            chk({tag, "_hold2"}, 32'(joy2), 32'(exp_j2));
            step();
        end
        ext_clk  = 1'b0;
        ext_load = 1'b0;
        ext_req  = 1'b0;
        step();
        chk({tag, "_rel_grant"}, 32'(ext_grant), 32'd0);
        chk({tag, "_rel_clk"}, 32'(joy_clk), 32'd1);
        chk({tag, "_rel_load"}, 32'(joy_load), 32'd1);
        chain_en = 1'b1;
    endtask

    initial begin
        reset    = 1'b1;
        ext_req  = 1'b0;
        ext_clk  = 1'b0;
        ext_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_outputs("reset");
        end
        reset = 1'b0;

        scan(16'hFF00, 0, 0, "scan_ff00");
        after_done(1'b0, "scan_ff00");
        scan(16'hA55A, 0, 0, "scan_a55a");
        for (int i = 0; i < 3; i++) begin
            after_done(1'b0, "scan_rand");
            scan(16'($urandom), 0, 0, "scan_rand");
        end

        // ext_req during SHIFT: scan finishes, grant follows DONE.
        after_done(1'b0, "pre_ext");
        scan(16'($urandom), 26, 0, "scan_ext");
        after_done(1'b1, "ext_shift");
        ext_phase(20, "ext_shift");
        scan(16'($urandom), 0, 0, "scan_post_ext");

        // ext_req in IDLE takes the chain without a scan.
        after_done(1'b0, "idle_req");
        ext_req = 1'b1;
        step();
        chk("idle_req_grant", 32'(ext_grant), 32'd1);
        chk("idle_req_valid", 32'(joy_valid), 32'd0);
        ext_phase(6, "ext_idle");
        scan(16'($urandom), 0, 0, "scan_post_idle_ext");

        // Reset during SHIFT bit 7 low phase aborts the scan.
        after_done(1'b0, "pre_rst");
        scan(16'($urandom), 0, 35, "scan_rst");
        scan(16'($urandom), 0, 0, "scan_post_rst");
        after_done(1'b0, "final");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
